ov7670_cache_writer: RTL and testbench

- Capture-side counterpart of the VGA cache reader: takes the OV7670 8-bit pixel bus (RGB565, two bytes per pixel) and assembles 16-bit pixels.
- Writes those pixels into the frame cache FIFO with a write-request strobe. The VGA timing block drains the same FIFO on the display side.
- Handles frame alignment after reset, sensor-settling frame skip, per-line and per-frame bounds clipping, and FIFO overflow reporting.

---
 rtl/ov7670_cache_writer.sv | 206 ++++++++++++++++++++
 tb/tb_ov7670_cache_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_cache_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ov7670_cache_writer -- OV7670 RGB565 byte-bus capture into the frame cache FIFO
// Rev 1.0
// ============================================================================
module ov7670_cache_writer #(
    parameter int H_PIXELS    = 800,
    parameter int V_LINES     = 600,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        CAM_VSYNC,
    input  logic        CAM_HREF,
    input  logic [7:0]  CAM_DATA,
    input  logic        CAPTURE_EN,
    input  logic        CACHE_FULL,
    output logic        CACHE_WREQ,
    output logic [15:0] CACHE_WDATA,
    output logic        FRAME_START,
    output logic        FRAME_DONE,
    output logic [7:0]  FRAME_CNT,
    output logic        OVERFLOW,
    output logic        LINE_ERR,
    output logic        FRAME_ERR
);

    localparam logic [11:0] H_LIM    = 12'(H_PIXELS);
    localparam logic [10:0] V_LIM    = 11'(V_LINES);
    localparam logic [7:0]  SKIP_LIM = 8'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SKIP      = 2'd1,
        ARMED     = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    logic        vsync_q, vsync_p_q, href_q, href_p_q;
    logic [7:0]  data_q;

    state_t      state_q, state_d;
    logic [7:0]  skip_cnt_q, skip_cnt_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        wreq_q, wreq_d;
    logic [15:0] wdata_q, wdata_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        ovf_q, ovf_d;
    logic        lerr_q, lerr_d;
    logic        ferr_q, ferr_d;

    logic        vs_rise, vs_fall, href_fall, in_win;

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            vsync_q   <= 1'b0;
            vsync_p_q <= 1'b0;
            href_q    <= 1'b0;
            href_p_q  <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            vsync_q   <= CAM_VSYNC;
            vsync_p_q <= vsync_q;
            href_q    <= CAM_HREF;
            href_p_q  <= href_q;
            data_q    <= CAM_DATA;
        end
    end

    assign vs_rise   = vsync_q & ~vsync_p_q;
    assign vs_fall   = ~vsync_q & vsync_p_q;
    assign href_fall = ~href_q & href_p_q;
    assign in_win    = (pix_cnt_q < H_LIM) && (line_cnt_q < V_LIM);

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        wreq_d     = 1'b0;
        wdata_d    = wdata_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        fcnt_d     = fcnt_q;
        ovf_d      = ovf_q;
        lerr_d     = lerr_q;
        ferr_d     = ferr_q;

        case (state_q)
            WAIT_SYNC: begin
                if (vs_rise) begin
                    skip_cnt_d = 8'd0;
                    state_d    = (SKIP_FRAMES == 0) ? ARMED : SKIP;
                end
            end
            SKIP: begin
                if (vs_rise) begin
                    skip_cnt_d = skip_cnt_q + 8'd1;
                    if (skip_cnt_q + 8'd1 == SKIP_LIM) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (vs_fall && CAPTURE_EN) begin
                    state_d    = CAPTURE;
                    start_d    = 1'b1;
                    pix_cnt_d  = 12'd0;
                    line_cnt_d = 11'd0;
                    phase_d    = 1'b0;
                    ovf_d      = 1'b0;
                    lerr_d     = 1'b0;
                end
            end
            CAPTURE: begin
                if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // Saturate so an absurdly long line can never wrap back into the window
                        if (pix_cnt_q != 12'hFFF) begin
                            pix_cnt_d = pix_cnt_q + 12'd1;
                        end
                        if (in_win && !CACHE_FULL) begin
                            wreq_d  = 1'b1;
                            wdata_d = {hi_q, data_q};
                        end else if (in_win) begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    if (line_cnt_q != 11'h7FF) begin
                        line_cnt_d = line_cnt_q + 11'd1;
                    end
                    pix_cnt_d = 12'd0;
                    phase_d   = 1'b0;
                    if (phase_q) begin
                        lerr_d = 1'b1;
                    end
                end
                if (vs_rise) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 8'd1;
                    ferr_d  = (line_cnt_q != V_LIM);
                    state_d = ARMED;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q    <= WAIT_SYNC;
            skip_cnt_q <= 8'd0;
            pix_cnt_q  <= 12'd0;
            line_cnt_q <= 11'd0;
            phase_q    <= 1'b0;
            hi_q       <= 8'h00;
            wreq_q     <= 1'b0;
            wdata_q    <= 16'h0000;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            fcnt_q     <= 8'd0;
            ovf_q      <= 1'b0;
            lerr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            wreq_q     <= wreq_d;
            wdata_q    <= wdata_d;
            start_q    <= start_d;
            done_q     <= done_d;
            fcnt_q     <= fcnt_d;
            ovf_q      <= ovf_d;
            lerr_q     <= lerr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign CACHE_WREQ  = wreq_q;
    assign CACHE_WDATA = wdata_q;
    assign FRAME_START = start_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_CNT   = fcnt_q;
    assign OVERFLOW    = ovf_q;
    assign LINE_ERR    = lerr_q;
    assign FRAME_ERR   = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_cache_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ov7670_cache_writer -- frame-level bench for the OV7670 cache writer
// Rev 1.0
// ============================================================================
module tb_ov7670_cache_writer;

    localparam int H  = 4;
    localparam int V  = 4;
    localparam int SK = 2;

    logic        SYS_CLK = 1'b0;
    logic        RST, CAM_VSYNC, CAM_HREF, CAPTURE_EN, CACHE_FULL;
    logic [7:0]  CAM_DATA;
    logic        CACHE_WREQ, FRAME_START, FRAME_DONE, OVERFLOW, LINE_ERR, FRAME_ERR;
    logic [15:0] CACHE_WDATA;
    logic [7:0]  FRAME_CNT;

    ov7670_cache_writer #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SK)) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF),
        .CAM_DATA(CAM_DATA), .CAPTURE_EN(CAPTURE_EN), .CACHE_FULL(CACHE_FULL),
        .CACHE_WREQ(CACHE_WREQ), .CACHE_WDATA(CACHE_WDATA), .FRAME_START(FRAME_START),
        .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT), .OVERFLOW(OVERFLOW),
        .LINE_ERR(LINE_ERR), .FRAME_ERR(FRAME_ERR)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        int cen, nlines, bytes, sp_line, sp_bytes, full_line, full_pix;
        int writes, ovf, lerr, ferr, first;
    } vec_t;

    int          checks = 0, failures = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          n_start = 0, n_done = 0;

    // reference model: frame index since reset and expected sticky outputs
    int          m_idx = 0, m_cap = 0, pending = 0;
    int          e_ovf = 0, e_lerr = 0, e_ferr = 0, e_fcnt = 0;
    int          t_valid = 0;
    vec_t        t_cur;
    int          lb[8];
    logic [7:0]  lf[8];

    always @(negedge SYS_CLK) begin
        if (!RST) begin
            if (CACHE_WREQ === 1'b1) got_q.push_back(CACHE_WDATA);
            if (FRAME_START === 1'b1) n_start++;
            if (FRAME_DONE === 1'b1) n_done++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero();
        chk("rst_wreq", CACHE_WREQ, 0);
        chk("rst_wdata", CACHE_WDATA, 0);
        chk("rst_start", FRAME_START, 0);
        chk("rst_done", FRAME_DONE, 0);
        chk("rst_fcnt", FRAME_CNT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_lerr", LINE_ERR, 0);
        chk("rst_ferr", FRAME_ERR, 0);
    endtask

    task automatic check_frame();
        int n;
        if (pending == 0) return;
        chk("nwrites", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("wdata", got_q[i], exp_q[i]);
        chk("frame_start_pulses", n_start, m_cap);
        chk("frame_done_pulses", n_done, m_cap);
        chk("frame_cnt", FRAME_CNT, e_fcnt & 255);
        chk("overflow", OVERFLOW, e_ovf);
        chk("line_err", LINE_ERR, e_lerr);
        chk("frame_err", FRAME_ERR, e_ferr);
        if (t_valid != 0) begin
            chk("tbl_writes", got_q.size(), t_cur.writes);
            chk("tbl_overflow", OVERFLOW, t_cur.ovf);
            chk("tbl_line_err", LINE_ERR, t_cur.lerr);
            chk("tbl_frame_err", FRAME_ERR, t_cur.ferr);
            if (t_cur.first != 0) chk("tbl_first_word", (got_q.size() > 0) ? got_q[0] : 16'h0, 16'hA0A1);
        end
        got_q.delete();
        exp_q.delete();
        n_start = 0;
        n_done  = 0;
        pending = 0;
    endtask

    // VSYNC pulse: its rise closes the previous frame, its fall opens the next
    task automatic vs_pulse();
        CAM_VSYNC = 1'b1;
        cyc(3);
        check_frame();
        CAM_VSYNC = 1'b0;
        cyc(3);
    endtask

    task automatic run_frame(input int cen, input int nlines, input int rnd);
        int         bi;
        logic [7:0] d, hi;
        int         p;
        bi = 0;
        hi = 8'h00;
        CAPTURE_EN = cen[0];
        vs_pulse();
        m_cap = (m_idx >= SK && cen != 0) ? 1 : 0;
        if (m_cap != 0) begin
            e_ovf  = 0;
            e_lerr = 0;
        end
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c <= lb[l]; c++) begin
                CACHE_FULL = (c >= 2 && c % 2 == 0) ? lf[l][c/2-1] : 1'b0;
                if (c < lb[l]) begin
                    d = (rnd != 0) ? 8'($urandom_range(0, 255)) : 8'(8'hA0 + bi);
                    bi++;
                    CAM_HREF = 1'b1;
                    CAM_DATA = d;
                    if (c % 2 == 0) begin
                        hi = d;
                    end else begin
                        p = c / 2;
                        if (m_cap != 0 && p < H && l < V) begin
                            if (lf[l][p]) e_ovf = 1;
                            else exp_q.push_back({hi, d});
                        end
                    end
                end else begin
                    CAM_HREF = 1'b0;
                end
                cyc(1);
            end
            CACHE_FULL = 1'b0;
            if (m_cap != 0 && lb[l] % 2 == 1) e_lerr = 1;
            cyc(3);
        end
        if (m_cap != 0) begin
            e_ferr = (nlines != V) ? 1 : 0;
            e_fcnt++;
        end
        m_idx++;
        pending = 1;
    endtask

    vec_t vt[12];
    int   dsnap;

    initial begin
        vt[0]  = '{1, 4, 8, -1, 0, -1, 0,  0, 0, 0, 0, 0};
        vt[1]  = '{1, 4, 8, -1, 0, -1, 0,  0, 0, 0, 0, 0};
        vt[2]  = '{1, 4, 8, -1, 0, -1, 0, 16, 0, 0, 0, 1};
        vt[3]  = '{1, 4, 8, -1, 0, -1, 0, 16, 0, 0, 0, 1};
        vt[4]  = '{1, 4, 8,  1, 12, -1, 0, 16, 0, 0, 0, 1};
        vt[5]  = '{1, 4, 8, -1, 0,  0, 1, 15, 1, 0, 0, 1};
        vt[6]  = '{1, 4, 8, -1, 0, -1, 0, 16, 0, 0, 0, 1};
        vt[7]  = '{1, 4, 8,  2, 7, -1, 0, 15, 0, 1, 0, 1};
        vt[8]  = '{1, 3, 8, -1, 0, -1, 0, 12, 0, 0, 1, 1};
        vt[9]  = '{1, 4, 8, -1, 0, -1, 0, 16, 0, 0, 0, 1};
        vt[10] = '{0, 4, 8, -1, 0, -1, 0,  0, 0, 0, 0, 0};
        vt[11] = '{1, 5, 8, -1, 0, -1, 0, 16, 0, 0, 1, 1};

        RST = 1'b1; CAM_VSYNC = 1'b0; CAM_HREF = 1'b0; CAM_DATA = 8'h00;
        CAPTURE_EN = 1'b1; CACHE_FULL = 1'b0;
        cyc(3);
        chk_outputs_zero();
        RST = 1'b0;
        cyc(2);

        for (int v = 0; v < 12; v++) begin
            for (int l = 0; l < 8; l++) begin
                lb[l] = (l == vt[v].sp_line) ? vt[v].sp_bytes : vt[v].bytes;
                lf[l] = (l == vt[v].full_line) ? 8'(1 << vt[v].full_pix) : 8'h00;
            end
            run_frame(vt[v].cen, vt[v].nlines, 0);
            t_valid = 1;
            t_cur   = vt[v];
        end

        for (int r = 0; r < 10; r++) begin
            for (int l = 0; l < 8; l++) begin
                lb[l] = $urandom_range(1, 12);
                lf[l] = 8'($urandom & $urandom);
            end
            run_frame(($urandom_range(0, 5) != 0) ? 1 : 0, $urandom_range(2, 6), 1);
            t_valid = 0;
        end

        // reset in the middle of a captured line
        CAPTURE_EN = 1'b1;
        vs_pulse();
        CAM_HREF = 1'b1;
        for (int c = 0; c < 4; c++) begin
            CAM_DATA = 8'(8'h5A + c);
            cyc(1);
        end
        dsnap = n_done;
        RST = 1'b1;
        cyc(1);
        chk_outputs_zero();
        CAM_HREF = 1'b0;
        cyc(2);
        RST = 1'b0;
        cyc(2);
        chk("no_done_on_reset", n_done, dsnap);
        m_idx = 0; m_cap = 0; pending = 0;
        e_ovf = 0; e_lerr = 0; e_ferr = 0; e_fcnt = 0;
        got_q.delete(); exp_q.delete();
        n_start = 0; n_done = 0;

        for (int l = 0; l < 8; l++) begin
            lb[l] = 8;
            lf[l] = 8'h00;
        end
        for (int f = 0; f < 3; f++) run_frame(1, 4, 0);
        vs_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
